mac_synapse_acc: RTL and testbench

MAC_SYNAPSE_ACC -- requirements
Module: mac_synapse_acc

---
 rtl/mac_pkg.sv | 45 ++++
 rtl/synapse_match.sv | 23 ++
 rtl/mac_synapse_acc.sv | 131 +++++++++++++
 tb/tb_mac_synapse_acc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the synaptic multiply-accumulate block: default sizes,
// controller states and the saturating adder used on every accumulation step.
package mac_pkg;

  localparam int N_CONN_DEF   = 8;
  localparam int ADDR_W_DEF   = 12;
  localparam int WEIGHT_W_DEF = 16;
  localparam int ACC_W_DEF    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; the sum is clamped to the signed
  // range of 'width' bits, so callers may use any accumulator width up to 63.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    sum     = a + b;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    r.sat   = 1'b0;
    r.value = sum;
    if (sum > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (sum < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/synapse_match.sv
// Single-cycle compare of an incoming spike address against every enabled
// connection entry; one match bit per entry so duplicate entries all fire.
module synapse_match
  import mac_pkg::*;
#(
  parameter int N_CONN = N_CONN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                            spike_valid,
  input  logic [ADDR_W-1:0]               spike_addr,
  input  logic [N_CONN-1:0]               entry_en,
  input  logic [N_CONN-1:0][ADDR_W-1:0]   entry_addr,
  output logic [N_CONN-1:0]               match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < N_CONN; i++) begin
      match[i] = spike_valid && entry_en[i] && (entry_addr[i] == spike_addr);
    end
  end

endmodule

// File: rtl/mac_synapse_acc.sv
// Per-timestep weighted sum of the synapses that saw a spike: spikes set bits
// in an incoming bitmap, timestep_end snapshots it and a serial walk adds weights.
module mac_synapse_acc
  import mac_pkg::*;
#(
  parameter int N_CONN   = N_CONN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(N_CONN)-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [WEIGHT_W-1:0]        cfg_weight,
  input  logic                       cfg_en,
  input  logic                       spike_valid,
  input  logic [ADDR_W-1:0]          spike_addr,
  input  logic                       timestep_end,
  output logic [ACC_W-1:0]           acc_out,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic                       acc_sat,
  output logic                       busy,
  output logic                       overrun,
  output state_t                     state
);

  localparam int IDX_W = $clog2(N_CONN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CONN - 1);

  logic [N_CONN-1:0][ADDR_W-1:0]   tbl_addr;
  logic [N_CONN-1:0][WEIGHT_W-1:0] tbl_weight;
  logic [N_CONN-1:0]               tbl_en;
  logic [N_CONN-1:0]               in_bm;
  logic [N_CONN-1:0]               work_bm;
  logic [N_CONN-1:0]               match;
  logic [IDX_W-1:0]                idx;
  logic signed [ACC_W-1:0]         acc;
  logic signed [WEIGHT_W-1:0]      weight_sel;
  logic                            acc_sat_r;
  logic                            acc_valid_r;
  logic                            overrun_r;
  state_t                          state_r;
  sat_res_t                        step;

  synapse_match #(
    .N_CONN (N_CONN),
    .ADDR_W (ADDR_W)
  ) u_match (
    .spike_valid (spike_valid),
    .spike_addr  (spike_addr),
    .entry_en    (tbl_en),
    .entry_addr  (tbl_addr),
    .match       (match)
  );

  always_comb begin
    weight_sel = tbl_weight[idx];
    step       = sat_add(64'(acc), 64'(weight_sel), ACC_W);
  end

  // Result handshake: acc_valid rises in DONE and, together with acc_out and
  // acc_sat, holds until a cycle where acc_valid && acc_ready; that edge
  // completes the transfer and the controller is back in IDLE after it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      tbl_addr    <= '0;
      tbl_weight  <= '0;
      tbl_en      <= '0;
      in_bm       <= '0;
      work_bm     <= '0;
      idx         <= '0;
      acc         <= '0;
      acc_sat_r   <= 1'b0;
      acc_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      state_r     <= IDLE;
    end else begin
      // A spike coincident with timestep_end belongs to the next timestep.
      if (timestep_end) in_bm <= match;
      else              in_bm <= in_bm | match;
      if (timestep_end && state_r != IDLE) overrun_r <= 1'b1;

      case (state_r)
        IDLE: begin
          if (cfg_we && int'(cfg_idx) < N_CONN) begin
            tbl_addr[cfg_idx]   <= cfg_addr;
            tbl_weight[cfg_idx] <= cfg_weight;
            tbl_en[cfg_idx]     <= cfg_en;
          end
          if (timestep_end) begin
            work_bm   <= in_bm;
            acc       <= '0;
            acc_sat_r <= 1'b0;
            idx       <= '0;
            state_r   <= ACCUM;
          end
        end
        ACCUM: begin
          if (work_bm[idx]) begin
            acc <= ACC_W'(step.value);
            if (step.sat) acc_sat_r <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            acc_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (acc_ready) begin
            acc_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign acc_out   = acc;
  assign acc_sat   = acc_sat_r;
  assign acc_valid = acc_valid_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r != IDLE);
  assign state     = state_r;

endmodule

// File: tb/tb_mac_synapse_acc.sv
// Directed bench: one 24-bit and one 17-bit accumulator instance share all
// stimulus; expected sums are hand-computed from the table contents.
module tb_mac_synapse_acc;
  import mac_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [2:0]         cfg_idx;
  logic [11:0]        cfg_addr;
  logic [15:0]        cfg_weight;
  logic               cfg_en;
  logic               spike_valid;
  logic [11:0]        spike_addr;
  logic               timestep_end;
  logic               acc_ready;

  logic signed [23:0] a24_out;
  logic               a24_valid, a24_sat, a24_busy, a24_ovr;
  state_t             st24;
  logic signed [16:0] a17_out;
  logic               a17_valid, a17_sat, a17_busy, a17_ovr;
  state_t             st17;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_synapse_acc #(.N_CONN(8), .ADDR_W(12), .WEIGHT_W(16), .ACC_W(24)) u_dut24 (
    .CLK (clk), .reset (reset), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
    .cfg_addr (cfg_addr), .cfg_weight (cfg_weight), .cfg_en (cfg_en),
    .spike_valid (spike_valid), .spike_addr (spike_addr), .timestep_end (timestep_end),
    .acc_out (a24_out), .acc_valid (a24_valid), .acc_ready (acc_ready), .acc_sat (a24_sat),
    .busy (a24_busy), .overrun (a24_ovr), .state (st24)
  );

  mac_synapse_acc #(.N_CONN(8), .ADDR_W(12), .WEIGHT_W(16), .ACC_W(17)) u_dut17 (
    .CLK (clk), .reset (reset), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
    .cfg_addr (cfg_addr), .cfg_weight (cfg_weight), .cfg_en (cfg_en),
    .spike_valid (spike_valid), .spike_addr (spike_addr), .timestep_end (timestep_end),
    .acc_out (a17_out), .acc_valid (a17_valid), .acc_ready (acc_ready), .acc_sat (a17_sat),
    .busy (a17_busy), .overrun (a17_ovr), .state (st17)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int idx, input int addr, input int weight, input bit en);
    cfg_we     = 1'b1;
    cfg_idx    = 3'(idx);
    cfg_addr   = 12'(addr);
    cfg_weight = 16'(weight);
    cfg_en     = en;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic spike(input int addr);
    spike_valid = 1'b1;
    spike_addr  = 12'(addr);
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic pulse_end();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
  endtask

  // Closes the timestep and checks latency (in edges from the pulse) and result.
  task automatic close_and_check(input string tag, input int exp24, input bit sat24,
                                 input int exp17, input bit sat17);
    int lat;
    pulse_end();
    lat = 1;
    while (!a24_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},   lat, 9);
    check({tag, "_v17"},   32'(a17_valid), 1);
    check({tag, "_out24"}, 32'(a24_out), exp24);
    check({tag, "_sat24"}, 32'(a24_sat), 32'(sat24));
    check({tag, "_out17"}, 32'(a17_out), exp17);
    check({tag, "_sat17"}, 32'(a17_sat), 32'(sat17));
  endtask

  task automatic accept();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("acc_valid_drop", 32'(a24_valid), 0);
    check("busy_drop", 32'(a24_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_weight = '0;
    cfg_en = 1'b0; spike_valid = 1'b0; spike_addr = '0; timestep_end = 1'b0;
    acc_ready = 1'b0;
    tick(2);
    check("rst_valid", 32'(a24_valid), 0);
    check("rst_busy", 32'(a24_busy), 0);
    check("rst_ovr", 32'(a24_ovr), 0);
    check("rst_out", 32'(a24_out), 0);
    check("rst_sat", 32'(a24_sat), 0);
    check("rst_state", 32'(st24), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Basic sum: entries 0..2 at addresses 0/1/2.
    cfg_write(0, 0, 72, 1'b1);
    cfg_write(1, 1, 19, 1'b1);
    cfg_write(2, 2, 50, 1'b1);
    spike(0);
    spike(2);
    close_and_check("basic", 122, 1'b0, 122, 1'b0);
    check("done_state", 32'(st24), 32'(DONE));
    accept();

    close_and_check("empty", 0, 1'b0, 0, 1'b0);
    accept();

    // Repeated spikes count once; unmatched address ignored.
    spike(1); spike(1); spike(1); spike(11);
    close_and_check("repeat", 19, 1'b0, 19, 1'b0);
    accept();

    // Second entry on address 1 with a negative weight contributes too.
    cfg_write(3, 1, -5, 1'b1);
    spike(1);
    close_and_check("dup", 14, 1'b0, 14, 1'b0);
    accept();

    // Config write while busy is dropped; spike while busy lands in the next timestep.
    pulse_end();
    cfg_write(4, 7, 100, 1'b1);
    spike(0);
    check("busy_accum", 32'(a24_busy), 1);
    tick(10);
    accept();
    spike(7);
    close_and_check("busy_wr", 72, 1'b0, 72, 1'b0);
    accept();

    // Spike in the write cycle matches the old (disabled) entry.
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_addr = 12'd9; cfg_weight = 16'd1000; cfg_en = 1'b1;
    spike_valid = 1'b1; spike_addr = 12'd9;
    tick();
    cfg_we = 1'b0; spike_valid = 1'b0;
    close_and_check("wr_old", 0, 1'b0, 0, 1'b0);
    accept();
    spike(9);
    close_and_check("wr_new", 1000, 1'b0, 1000, 1'b0);
    accept();

    // Spike coincident with timestep_end goes to the following timestep.
    spike(0);
    spike_valid = 1'b1; spike_addr = 12'd2; timestep_end = 1'b1;
    tick();
    spike_valid = 1'b0; timestep_end = 1'b0;
    tick(7);
    check("coinc_v", 32'(a24_valid), 0);
    tick();
    check("coinc_v9", 32'(a24_valid), 1);
    check("coinc_out", 32'(a24_out), 72);
    accept();
    close_and_check("coinc_next", 50, 1'b0, 50, 1'b0);
    accept();

    // Backpressure plus a dropped timestep while in DONE.
    spike(1);
    close_and_check("bp", 14, 1'b0, 14, 1'b0);
    spike(0);
    check("bp_hold1", 32'(a24_out), 14);
    pulse_end();
    check("bp_ovr", 32'(a24_ovr), 1);
    check("bp_ovr17", 32'(a17_ovr), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_out", 32'(a24_out), 14);
      check("bp_hold_valid", 32'(a24_valid), 1);
    end
    accept();
    spike(2);
    close_and_check("bp_next", 50, 1'b0, 50, 1'b0);
    accept();
    check("ovr_sticky", 32'(a24_ovr), 1);

    // Saturation: eight max-positive then eight max-negative weights.
    for (int i = 0; i < 8; i++) cfg_write(i, 20 + i, 32767, 1'b1);
    for (int i = 0; i < 8; i++) spike(20 + i);
    close_and_check("sat_pos", 262136, 1'b0, 65535, 1'b1);
    accept();
    for (int i = 0; i < 8; i++) cfg_write(i, 20 + i, -32768, 1'b1);
    for (int i = 0; i < 8; i++) spike(20 + i);
    close_and_check("sat_neg", -262144, 1'b0, -65536, 1'b1);
    accept();

    // Reset mid-ACCUM abandons the computation and clears the table.
    spike(20);
    pulse_end();
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(a24_busy), 0);
    check("mid_rst_valid", 32'(a24_valid), 0);
    check("mid_rst_ovr", 32'(a24_ovr), 0);
    tick(10);
    check("mid_rst_nopulse", 32'(a24_valid), 0);
    spike(20);
    spike(0);
    close_and_check("post_rst", 0, 1'b0, 0, 1'b0);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
